// File: rtl/fsm3_pkg.sv
// Shared types and helpers for the 3-state step FSM arbiter.
package fsm3_pkg;

    // Step FSM state encodings (shadow copy uses the same values).
    localparam logic [1:0] S0    = 2'b00;
    localparam logic [1:0] S1    = 2'b01;
    localparam logic [1:0] S2    = 2'b10;
    localparam logic [1:0] S_INV = 2'b11;

    // Arbiter controller states.
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        STEP,
        CHECK,
        DONE
    } ctrl_state_t;

    // State reached after one din pulse; S2 wraps to S0.
    function automatic logic [1:0] next3(input logic [1:0] s);
        logic [1:0] r;
        case (s)
            S0:      r = S1;
            S1:      r = S2;
            default: r = S0;
        endcase
        return r;
    endfunction

    // Number of pulses needed to move from 'from' to 'to', i.e. (to-from) mod 3.
    // Only meaningful for valid (non-S_INV) encodings.
    function automatic logic [1:0] dist3(input logic [1:0] from, input logic [1:0] to);
        logic [2:0] t;
        t = {1'b0, to} + 3'd3 - {1'b0, from};
        if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/fsm3_step_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_picker #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin : pick
        logic [IDXW:0]   sum;
        logic [IDXW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDXW+1)'(k);
            if (sum >= (IDXW+1)'(N)) begin
                sum = sum - (IDXW+1)'(N);
            end
            cand = sum[IDXW-1:0];
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fsm3_step_arbiter.sv
// Round-robin controller sharing one 3-state cyclic step FSM among N requesters.
// Grants one requester, pulses fsm_din the required number of times, checks
// fsm_dout against a shadow state, then acknowledges.
module fsm3_step_arbiter
    import fsm3_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [2*N-1:0]    tgt,
    output logic [N-1:0]      ack,
    output logic              ack_err,
    output logic              busy,
    output logic [IDXW-1:0]   grant_idx,
    output logic [1:0]        cur_state,
    output logic              fsm_rst,
    output logic              fsm_din,
    input  logic              fsm_dout,
    output logic              mismatch,
    input  logic              clr_mismatch
);

    ctrl_state_t     state, state_nx;
    logic [IDXW-1:0] ptr;
    logic [1:0]      steps_q;
    logic [1:0]      tgt_q;
    logic            last_done;
    logic [N-1:0]    done_mask;
    logic [N-1:0]    req_eff;
    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic [1:0]      tgt_pick;
    logic [1:0]      steps_pick;
    logic            mm_hit;

    // Requester acked in the previous cycle is ignored for one IDLE cycle,
    // giving its client time to drop req.
    always_comb begin
        done_mask = '0;
        if (last_done) begin
            done_mask[grant_idx] = 1'b1;
        end
    end

    assign req_eff = req & ~done_mask;

    rr_picker #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req_eff),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign tgt_pick   = tgt[{pick_idx, 1'b0} +: 2];
    assign steps_pick = dist3(cur_state, tgt_pick);

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            INIT:  state_nx = IDLE;
            IDLE: begin
                if (pick_valid) begin
                    if (tgt_pick == S_INV) begin
                        state_nx = DONE;
                    end else if (steps_pick == 2'd0) begin
                        state_nx = CHECK;
                    end else begin
                        state_nx = STEP;
                    end
                end
            end
            STEP: begin
                if (steps_q == 2'd1) begin
                    state_nx = CHECK;
                end
            end
            CHECK: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    // Moore outputs decoded from the controller state. fsm_rst is gated by the
    // reset input so it stays low while reset is held and pulses for the single
    // INIT cycle after release.
    always_comb begin
        ack     = '0;
        ack_err = 1'b0;
        busy    = (state != IDLE);
        fsm_din = (state == STEP);
        fsm_rst = (state == INIT) && rst;
        if (state == DONE) begin
            ack[grant_idx] = 1'b1;
            ack_err        = (tgt_q == S_INV);
        end
    end

    // Grant, target, step count, shadow state and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_idx <= '0;
            ptr       <= '0;
            cur_state <= S0;
            steps_q   <= '0;
            tgt_q     <= S0;
            last_done <= 1'b0;
        end else begin
            last_done <= (state == DONE);
            case (state)
                INIT: cur_state <= S0;
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        tgt_q     <= tgt_pick;
                        steps_q   <= (tgt_pick == S_INV) ? 2'd0 : steps_pick;
                    end
                end
                STEP: begin
                    cur_state <= next3(cur_state);
                    steps_q   <= steps_q - 2'd1;
                end
                DONE: begin
                    ptr <= (grant_idx == IDXW'(N-1)) ? '0 : grant_idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    assign mm_hit = (state == CHECK) && (fsm_dout != (cur_state == S2));

    // Sticky mismatch flag; a fresh mismatch takes priority over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch <= 1'b0;
        end else if (mm_hit) begin
            mismatch <= 1'b1;
        end else if (clr_mismatch) begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm3_step_arbiter.sv
// Self-checking bench for fsm3_step_arbiter with a behavioural step FSM and
// a transaction-level reference model.
module tb_fsm3_step_arbiter;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [2*N-1:0]  tgt;
    logic [N-1:0]    ack;
    logic            ack_err;
    logic            busy;
    logic [IDXW-1:0] grant_idx;
    logic [1:0]      cur_state;
    logic            fsm_rst;
    logic            fsm_din;
    logic            fsm_dout;
    logic            mismatch;
    logic            clr_mismatch;

    logic [1:0] sfsm = 2'd1;
    logic       force_low;

    int checks;
    int errs;
    int m_ptr;
    int m_cur;
    int m_mm;

    always #5 clk = ~clk;

    fsm3_step_arbiter #(
        .N    (N),
        .IDXW (IDXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .tgt          (tgt),
        .ack          (ack),
        .ack_err      (ack_err),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .cur_state    (cur_state),
        .fsm_rst      (fsm_rst),
        .fsm_din      (fsm_din),
        .fsm_dout     (fsm_dout),
        .mismatch     (mismatch),
        .clr_mismatch (clr_mismatch)
    );

    // Shared 3-state step FSM: sync reset, advances on din, output high in S2.
    always @(posedge clk) begin
        if (fsm_rst) sfsm <= 2'd0;
        else if (fsm_din) sfsm <= (sfsm == 2'd2) ? 2'd0 : sfsm + 2'd1;
    end
    assign fsm_dout = (sfsm == 2'd2) && !force_low;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serve one request: model predicts winner, latency, pulses, final state.
    task automatic serve(input string tag, input int use_force, input int scramble);
        int idx, tv, steps, lat, n, pulses, both, nxt, c;
        idx = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (idx < 0 && req[c]) idx = c;
        end
        if (idx < 0) begin
            chk({tag, "_noreq"}, 0, 1);
            return;
        end
        tv = int'((tgt >> (2 * idx)) & 8'h3);
        if (tv == 3) begin
            steps = 0;
            lat   = 2;
            nxt   = m_cur;
        end else begin
            steps = ((tv - m_cur) % 3 + 3) % 3;
            lat   = steps + 3;
            nxt   = tv;
        end

        @(negedge clk);
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 32'(n < 20), 1);
        chk({tag, "_grant"}, 32'(grant_idx), idx);
        if (scramble != 0) begin
            tgt[2*idx +: 2] = 2'($urandom);
            req[idx] = 1'b0;
        end
        if (use_force != 0) force_low = 1'b1;

        n = 0;
        pulses = 0;
        both = 0;
        while (1) begin
            n++;
            pulses += int'(fsm_din);
            both |= int'(fsm_din & fsm_rst);
            if (ack !== '0 || n >= 12) break;
            @(negedge clk);
        end

        if (use_force != 0 && nxt == 2 && tv != 3) m_mm = 1;
        else if (clr_mismatch) m_mm = 0;

        chk({tag, "_ack"}, 32'(ack), 32'(1) << idx);
        chk({tag, "_ackerr"}, 32'(ack_err), 32'(tv == 3));
        chk({tag, "_lat"}, n, lat - 1);
        chk({tag, "_pulses"}, pulses, steps);
        chk({tag, "_cur"}, 32'(cur_state), nxt);
        chk({tag, "_dout"}, 32'(fsm_dout), 32'(nxt == 2 && use_force == 0));
        chk({tag, "_mm"}, 32'(mismatch), m_mm);
        chk({tag, "_dinrst"}, both, 0);

        force_low = 1'b0;
        req[idx] = 1'b0;
        m_ptr = (idx + 1) % N;
        m_cur = nxt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mask;
        rst = 1'b1;
        req = '0;
        tgt = '0;
        clr_mismatch = 1'b0;
        force_low = 1'b0;
        checks = 0;
        errs = 0;
        m_ptr = 0;
        m_cur = 0;
        m_mm = 0;

        // Asynchronous reset values
        #2 rst = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_ackerr", 32'(ack_err), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_din", 32'(fsm_din), 0);
        chk("rst_fsmrst", 32'(fsm_rst), 0);
        chk("rst_mm", 32'(mismatch), 0);
        chk("rst_cur", 32'(cur_state), 0);
        chk("rst_grant", 32'(grant_idx), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("init_fsmrst", 32'(fsm_rst), 1);
        chk("init_din", 32'(fsm_din), 0);
        @(negedge clk);
        chk("idle_fsmrst", 32'(fsm_rst), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_dout", 32'(fsm_dout), 0);

        // Single request S0 -> S2
        req = 4'b0001;
        tgt = 8'b00_00_00_10;
        serve("single", 0, 0);
        // Wrap S2 -> S1
        req[1] = 1'b1;
        tgt[3:2] = 2'b01;
        serve("wrap", 0, 0);
        // Zero-step request
        req[2] = 1'b1;
        tgt[5:4] = 2'b01;
        serve("zero", 0, 0);
        // Invalid target
        req[3] = 1'b1;
        tgt[7:6] = 2'b11;
        serve("inval", 0, 0);

        // Fairness: all requesting, then 3 and 0 with pointer at 0
        req = 4'b1111;
        tgt = 8'($urandom);
        for (int i = 0; i < 4; i++) serve("fair", 0, 0);
        req = 4'b1001;
        serve("fair2", 0, 0);
        serve("fair3", 0, 0);

        // Mismatch: land in S2 with dout forced low
        req[1] = 1'b1;
        tgt[3:2] = 2'b10;
        serve("mm_set", 1, 0);
        @(negedge clk);
        chk("mm_sticky", 32'(mismatch), 1);
        clr_mismatch = 1'b1;
        @(negedge clk);
        clr_mismatch = 1'b0;
        m_mm = 0;
        chk("mm_clr", 32'(mismatch), 0);
        req[2] = 1'b1;
        tgt[5:4] = 2'b10;
        serve("mm_set2", 1, 0);
        clr_mismatch = 1'b1;
        req[3] = 1'b1;
        tgt[7:6] = 2'b10;
        serve("mm_clrhit", 1, 0);
        clr_mismatch = 1'b0;
        @(negedge clk);
        chk("mm_win", 32'(mismatch), 1);
        clr_mismatch = 1'b1;
        @(negedge clk);
        clr_mismatch = 1'b0;
        m_mm = 0;
        chk("mm_clr2", 32'(mismatch), 0);

        // Asynchronous reset in the middle of STEP
        req[0] = 1'b1;
        tgt[1:0] = 2'b01;
        mask = 0;
        while (fsm_din !== 1'b1 && mask < 20) begin
            @(negedge clk);
            mask++;
        end
        chk("ar_step", 32'(mask < 20), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        req = '0;
        #1;
        chk("ar_ack", 32'(ack), 0);
        chk("ar_busy", 32'(busy), 1);
        chk("ar_din", 32'(fsm_din), 0);
        chk("ar_fsmrst", 32'(fsm_rst), 0);
        chk("ar_cur", 32'(cur_state), 0);
        chk("ar_grant", 32'(grant_idx), 0);
        chk("ar_mm", 32'(mismatch), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_init", 32'(fsm_rst), 1);
        chk("ar_init_ack", 32'(ack), 0);
        @(negedge clk);
        chk("ar_idle_rst", 32'(fsm_rst), 0);
        chk("ar_idle_busy", 32'(busy), 0);
        chk("ar_idle_ack", 32'(ack), 0);
        chk("ar_idle_dout", 32'(fsm_dout), 0);
        m_ptr = 0;
        m_cur = 0;
        m_mm = 0;
        req[2] = 1'b1;
        tgt[5:4] = 2'b01;
        serve("ar_after", 0, 0);

        // Randomized batches of simultaneous requests
        for (int it = 0; it < 25; it++) begin
            mask = $urandom_range(1, 15);
            req = 4'(mask);
            tgt = 8'($urandom);
            for (int s = 0; s < N && req != '0; s++) begin
                serve("rand", 0, int'($urandom_range(0, 1)));
            end
            chk("rand_drain", 32'(req), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/fsm3_step_arbiter.md
Name: fsm3_step_arbiter

Overview:
- Round-robin controller that shares one 3-state cyclic step FSM among N requesters.
- The FSM cycles S0->S1->S2->S0 on each cycle its din is high, and its dout is high only in S2.
- Each requester asks for the FSM to be moved to a target state. This block grants one requester at a time, issues the required din pulses, checks the FSM's dout against a shadow copy of its state, and acknowledges.
- It sits between client logic and the step FSM instance, and owns that FSM's synchronous reset and din.

Parameters:
- N, 4, number of requesters (2..8).
- IDXW, $clog2(N), width of the grant index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- req  in  N  per-requester request; held high until the matching ack.
- tgt  in  2*N  per-requester target state, flattened; requester i uses bits [2i+1:2i]; 00=S0, 01=S1, 10=S2, 11=invalid.
- ack  out  N  one-cycle pulse to the serviced requester.
- ack_err  out  1  valid with ack; 1 = invalid target, request rejected.
- busy  out  1  high in any state other than IDLE.
- grant_idx  out  IDXW  index of the requester currently being served.
- cur_state  out  2  shadow of the FSM state.
- fsm_rst  out  1  active-high synchronous reset to the step FSM.
- fsm_din  out  1  step pulse to the step FSM.
- fsm_dout  in  1  step FSM output (1 only in S2).
- mismatch  out  1  sticky: fsm_dout disagreed with the shadow state.
- clr_mismatch  in  1  clears mismatch; a new mismatch in the same cycle wins.

Behaviour:
- Reset (rst=0, async) values:
  - ctrl state INIT, cur_state=00, rr pointer=0, grant_idx=0.
  - ack=0, ack_err=0, busy=1, fsm_din=0, fsm_rst=0, mismatch=0.
- Controller states: INIT, IDLE, STEP, CHECK, DONE.
- INIT:
  - fsm_rst=1 for exactly one cycle; cur_state=S0; next IDLE.
  - Reset mid-operation always returns here, so the FSM is resynchronised.
- IDLE:
  - If any req bit is high, pick the first requester at or after the rr pointer, wrapping modulo N.
  - Register grant_idx, the target, and steps = (tgt - cur_state) mod 3, a 2-bit value in 0..2.
  - tgt=11: go to DONE with the error flag set; no pulses are issued.
  - steps=0: go to CHECK (zero pulses).
  - Otherwise go to STEP.
  - With no request, stay in IDLE; busy=0.
- STEP:
  - fsm_din=1 every cycle in this state.
  - cur_state advances at each clock edge in step with the FSM (S2 wraps to S0); steps decrements.
  - Leave for CHECK on the edge where steps goes 1->0, so exactly `steps` pulses are issued back to back.
- CHECK:
  - fsm_din=0.
  - Compare fsm_dout with (cur_state==S2). On inequality, set mismatch.
  - Next DONE.
- DONE:
  - ack[grant_idx]=1 for one cycle; ack_err=error flag.
  - rr pointer = grant_idx+1, wrapping to 0 after N-1.
  - Next IDLE.
- Latency from the req sampled in IDLE to ack:
  - valid target: steps+3 cycles (IDLE, steps x STEP, CHECK, DONE).
  - invalid target: 2 cycles.
- A client must not re-request earlier than the cycle after its ack.
- The controller ignores req in IDLE on the cycle following DONE only if that req is the one just acked and is still high; the client deasserts on ack.
- If req drops while the request is being served, servicing completes and ack is still issued.
- Changes to tgt after grant are ignored because the target is latched in IDLE.
- Simultaneous requests are resolved strictly round robin; no requester waits more than N-1 grants.
- fsm_din and fsm_rst are never high in the same cycle.

Decomposition:
- Package fsm3_pkg holds:
  - the state encodings S0=2'b00, S1=2'b01, S2=2'b10, S_INV=2'b11;
  - the ctrl_state_t enum (INIT, IDLE, STEP, CHECK, DONE);
  - function next3(s), returning S0 after S2;
  - function dist3(from, to), returning (to-from) mod 3.
- One sub-module: rr_picker (N-bit request, IDXW pointer -> valid plus index), purely combinational.
- The bench instantiates the existing 3-state step FSM as the shared resource, with its sync reset driven by fsm_rst.

Test Plan:
- Single request: after reset and INIT, req[0]=1 with tgt0=10. Expect 2 fsm_din pulses on consecutive cycles, then cur_state=10, fsm_dout=1, ack[0] 5 cycles after grant, ack_err=0, mismatch=0.
- Wrap-around: from S2, req[1] with tgt1=01. Expect steps=2 (S2->S0->S1), cur_state=01, fsm_dout=0, ack[1].
- Zero-step and invalid targets:
  - request for the current state: no din pulses, ack after 3 cycles.
  - tgt=11: ack with ack_err=1 after 2 cycles, cur_state unchanged.
- Arbitration fairness with N=4: all req high and the pointer at 0. Expect grants in order 0,1,2,3 with one ack each; then, with the pointer at 0 again, hold req[3] and req[0] so the next grant is 0.
- Mismatch detection: force fsm_dout=0 while cur_state=S2 in CHECK. Expect mismatch=1 and sticky. Then clr_mismatch=1 clears it the next cycle; with clr_mismatch and a new mismatch in the same cycle, mismatch stays 1.
- Async reset mid-STEP: rst=0 between clock edges. Expect all outputs at reset values immediately, then a one-cycle fsm_rst=1, cur_state=00, no ack for the aborted request, and normal service afterwards.
